capture_timer: RTL and testbench

Parametrised microsecond timebase with multi-channel pulse-width capture, for PPM/servo receiver decoding.
Prescales clk to a 1 us tick and maintains a free-running WIDTH-bit microsecond counter.
Each of CHANNELS inputs is synchronised and timestamped on its rising edge; its high-time is measured against the counter.
Results are presented per channel with a valid/ack handshake to the downstream PPM decoder.

---
 rtl/capture_timer_pkg.sv | 20 ++
 rtl/capture_timer_channel.sv | 173 +++++++++++++++++
 rtl/capture_timer.sv | 89 ++++++++
 tb/tb_capture_timer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_timer_pkg.sv
// capture_timer_pkg
//   Shared types and helpers for the capture_timer block.
//   - chan_state_t : per-channel capture FSM states
//   - prescaler_width() : bit width of the microsecond prescaler counter
package capture_timer_pkg;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    HIGH      = 2'd1,
    WAIT_LOW  = 2'd2
  } chan_state_t;

  // max(1, clog2(ticks)): a 1-cycle-per-us prescaler still needs one bit.
  function automatic int prescaler_width(input int ticks_per_us);
    int w;
    w = $clog2(ticks_per_us);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/capture_timer_channel.sv
// capture_channel
//   One pulse-width capture channel: input synchroniser, edge detector,
//   capture FSM and valid/ack result handshake.
//   Optional feature macro: PULSE_TIMEOUT_EN (forced capture after
//   TIMEOUT_US microseconds of high time).
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   clear              synchronous clear of FSM and flags
//   in_pulse           asynchronous pulse input
//   micros             shared microsecond timebase
//   cap_ack            consume the pending result
//   cap_valid          result pending
//   cap_stamp          micros at the rising edge
//   cap_width          high time in microseconds
//   cap_overrun        sticky: a pending result was overwritten
//   cap_timeout        current result was forced by timeout
module capture_channel
  import capture_timer_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_US  = 2500
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_pulse,
  input  logic [WIDTH-1:0] micros,
  input  logic             cap_ack,
  output logic             cap_valid,
  output logic [WIDTH-1:0] cap_stamp,
  output logic [WIDTH-1:0] cap_width,
  output logic             cap_overrun,
  output logic             cap_timeout
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   last_reg;
  logic                   rise;
  logic                   fall;

  chan_state_t      state_reg, state_next;
  logic [WIDTH-1:0] start_reg, start_next;
  logic [WIDTH-1:0] stamp_reg, stamp_next;
  logic [WIDTH-1:0] width_reg, width_next;
  logic             valid_reg, valid_next;
  logic             overrun_reg, overrun_next;
  logic [WIDTH-1:0] elapsed;
  logic [WIDTH-1:0] cap_w;
  logic             capture;

  // Synchroniser chain plus one flop holding the previous synchronised level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= '0;
      last_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], in_pulse};
      last_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign rise = sync_reg[SYNC_STAGES-1] & ~last_reg;
  assign fall = ~sync_reg[SYNC_STAGES-1] & last_reg;

  // Modular subtraction keeps the width correct across a micros wrap.
  assign elapsed = micros - start_reg;

`ifdef PULSE_TIMEOUT_EN
  localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT_US);
  logic forced;
  logic timeout_reg;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= WAIT_RISE;
      start_reg   <= '0;
      stamp_reg   <= '0;
      width_reg   <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      start_reg   <= start_next;
      stamp_reg   <= stamp_next;
      width_reg   <= width_next;
      valid_reg   <= valid_next;
      overrun_reg <= overrun_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    start_next   = start_reg;
    stamp_next   = stamp_reg;
    width_next   = width_reg;
    valid_next   = valid_reg;
    overrun_next = overrun_reg;
    capture      = 1'b0;
    cap_w        = elapsed;
`ifdef PULSE_TIMEOUT_EN
    forced       = 1'b0;
`endif

    case (state_reg)
      WAIT_RISE: begin
        if (rise) begin
          state_next = HIGH;
          start_next = micros;
        end
      end
      HIGH: begin
`ifdef PULSE_TIMEOUT_EN
        if (elapsed >= TIMEOUT_W) begin
          capture    = 1'b1;
          forced     = 1'b1;
          cap_w      = TIMEOUT_W;
          // If the fall lands on the same cycle, skip WAIT_LOW entirely.
          state_next = fall ? WAIT_RISE : WAIT_LOW;
        end else
`endif
        if (fall) begin
          capture    = 1'b1;
          state_next = WAIT_RISE;
        end
      end
`ifdef PULSE_TIMEOUT_EN
      WAIT_LOW: begin
        if (fall) state_next = WAIT_RISE;
      end
`endif
      default: state_next = WAIT_RISE;
    endcase

    // A new capture beats a simultaneous ack; overrun only when the old
    // result is lost without having been acknowledged.
    if (capture) begin
      stamp_next = start_reg;
      width_next = cap_w;
      valid_next = 1'b1;
      if (valid_reg && !cap_ack) overrun_next = 1'b1;
    end else if (valid_reg && cap_ack) begin
      valid_next = 1'b0;
    end

    // Clear leaves the last stamp/width visible.
    if (clear) begin
      state_next   = WAIT_RISE;
      valid_next   = 1'b0;
      overrun_next = 1'b0;
    end
  end

`ifdef PULSE_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        timeout_reg <= 1'b0;
    else if (clear)   timeout_reg <= 1'b0;
    else if (capture) timeout_reg <= forced;
  end
  assign cap_timeout = timeout_reg;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_US != 0);
  assign cap_timeout    = 1'b0;
`endif

  assign cap_valid   = valid_reg;
  assign cap_stamp   = stamp_reg;
  assign cap_width   = width_reg;
  assign cap_overrun = overrun_reg;

endmodule

// File: rtl/capture_timer.sv
// capture_timer
//   Microsecond timebase with CHANNELS pulse-width capture channels for
//   PPM/servo receiver decoding.
//   Optional feature macro: PULSE_TIMEOUT_EN (see capture_channel).
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   enable        1 = prescaler and micros advance, 0 = frozen
//   clear         synchronous clear of timebase, channel FSMs and flags
//   in_pulse      asynchronous pulse inputs, one per channel
//   micros        free-running microsecond count
//   tick          one-cycle pulse on each micros increment
//   cap_valid     per-channel result pending
//   cap_ack       per-channel result consume
//   cap_stamp     per-channel micros at rising edge, channel i at [i*WIDTH +: WIDTH]
//   cap_width     per-channel high time in us, same packing as cap_stamp
//   cap_overrun   per-channel sticky overwrite flag
//   cap_timeout   per-channel forced-by-timeout flag
module capture_timer
  import capture_timer_pkg::*;
#(
  parameter int TICKS_PER_US = 50,
  parameter int WIDTH        = 32,
  parameter int CHANNELS     = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int TIMEOUT_US   = 2500
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [CHANNELS-1:0]       in_pulse,
  output logic [WIDTH-1:0]          micros,
  output logic                      tick,
  output logic [CHANNELS-1:0]       cap_valid,
  input  logic [CHANNELS-1:0]       cap_ack,
  output logic [CHANNELS*WIDTH-1:0] cap_stamp,
  output logic [CHANNELS*WIDTH-1:0] cap_width,
  output logic [CHANNELS-1:0]       cap_overrun,
  output logic [CHANNELS-1:0]       cap_timeout
);

  localparam int            PW       = prescaler_width(TICKS_PER_US);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_US - 1);

  logic [PW-1:0]    pre_cnt_reg;
  logic [WIDTH-1:0] micros_reg;

  assign tick = enable & (pre_cnt_reg == PRE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt_reg <= '0;
      micros_reg  <= '0;
    end else if (clear) begin
      pre_cnt_reg <= '0;
      micros_reg  <= '0;
    end else if (enable) begin
      if (tick) begin
        pre_cnt_reg <= '0;
        micros_reg  <= micros_reg + WIDTH'(1);
      end else begin
        pre_cnt_reg <= pre_cnt_reg + PW'(1);
      end
    end
  end

  assign micros = micros_reg;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    capture_channel #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .TIMEOUT_US  (TIMEOUT_US)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .in_pulse    (in_pulse[gi]),
      .micros      (micros_reg),
      .cap_ack     (cap_ack[gi]),
      .cap_valid   (cap_valid[gi]),
      .cap_stamp   (cap_stamp[gi*WIDTH +: WIDTH]),
      .cap_width   (cap_width[gi*WIDTH +: WIDTH]),
      .cap_overrun (cap_overrun[gi]),
      .cap_timeout (cap_timeout[gi])
    );
  end

endmodule

// File: tb/tb_capture_timer.sv
// tb_capture_timer
//   Three instances share clk/reset/enable/clear:
//   u_def  : default parameters (50 clk per us) for the timebase
//   u_main : 2 clk per us, 16-bit, 4 channels, 300 us timeout
//   u_w8   : 2 clk per us, 8-bit, 1 channel, for micros wrap
module tb_capture_timer;

  logic clk = 1'b0;
  logic reset;
  logic enable = 1'b1;
  logic clear  = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]   in_def  = '0;
  logic [3:0]   ack_def = '0;
  logic [31:0]  micros_def;
  logic         tick_def;
  logic [3:0]   valid_def, ovr_def, to_def;
  logic [127:0] stamp_def, width_def;

  logic [3:0]   in_main  = '0;
  logic [3:0]   ack_main = '0;
  logic [15:0]  micros_main;
  logic         tick_main;
  logic [3:0]   valid_main, ovr_main, to_main;
  logic [63:0]  stamp_main, width_main;

  logic [0:0]   in_w8  = '0;
  logic [0:0]   ack_w8 = '0;
  logic [7:0]   micros_w8;
  logic         tick_w8;
  logic [0:0]   valid_w8, ovr_w8, to_w8;
  logic [7:0]   stamp_w8, width_w8;

  capture_timer u_def (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .in_pulse(in_def), .micros(micros_def), .tick(tick_def),
    .cap_valid(valid_def), .cap_ack(ack_def), .cap_stamp(stamp_def),
    .cap_width(width_def), .cap_overrun(ovr_def), .cap_timeout(to_def)
  );

  capture_timer #(.TICKS_PER_US(2), .WIDTH(16), .CHANNELS(4), .TIMEOUT_US(300)) u_main (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .in_pulse(in_main), .micros(micros_main), .tick(tick_main),
    .cap_valid(valid_main), .cap_ack(ack_main), .cap_stamp(stamp_main),
    .cap_width(width_main), .cap_overrun(ovr_main), .cap_timeout(to_main)
  );

  capture_timer #(.TICKS_PER_US(2), .WIDTH(8), .CHANNELS(1)) u_w8 (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .in_pulse(in_w8), .micros(micros_w8), .tick(tick_w8),
    .cap_valid(valid_w8), .cap_ack(ack_w8), .cap_stamp(stamp_w8),
    .cap_width(width_w8), .cap_overrun(ovr_w8), .cap_timeout(to_w8)
  );

  // Reference timebase for 2 clk per us: used to predict capture stamps.
  logic [15:0] model_micros;
  logic        model_pre;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_micros <= '0;
      model_pre    <= 1'b0;
    end else if (clear) begin
      model_micros <= '0;
      model_pre    <= 1'b0;
    end else if (enable) begin
      if (model_pre) begin
        model_pre    <= 1'b0;
        model_micros <= model_micros + 16'd1;
      end else begin
        model_pre <= 1'b1;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input bit on_w8, input int ch, input logic lvl);
    if (on_w8) in_w8[0] = lvl;
    else       in_main[ch] = lvl;
  endtask

  // Called at a negedge. Holds the input high for 'cycles' clocks and
  // returns at the negedge after the fall has been acted on. The stamp is
  // the model micros just before the rise is acted on.
  task automatic do_pulse(input bit on_w8, input int ch, input int cycles,
                          input bit ack_at_fall, output logic [15:0] stamp);
    set_in(on_w8, ch, 1'b1);
    @(posedge clk); @(posedge clk); @(negedge clk);
    stamp = model_micros;
    repeat (cycles - 2) @(negedge clk);
    set_in(on_w8, ch, 1'b0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    if (ack_at_fall) ack_main[ch] = 1'b1;
    @(posedge clk); @(negedge clk);
    ack_main[ch] = 1'b0;
  endtask

  typedef struct {
    int ch;
    int high_us;
    bit ack_before;
    int exp_width;
    bit exp_overrun;
    bit exp_timeout;
  } rec_t;

  rec_t tbl[7];

  initial begin
    logic [15:0] st;
    int ticks, last_k, guard;

    tbl[0] = '{0, 1500, 1'b0, 1500, 1'b0, 1'b0};
    tbl[1] = '{1,  100, 1'b0,  100, 1'b0, 1'b0};
    tbl[2] = '{1,  120, 1'b0,  120, 1'b1, 1'b0};
    tbl[3] = '{2,    1, 1'b0,    1, 1'b0, 1'b0};
    tbl[4] = '{3,   37, 1'b0,   37, 1'b0, 1'b0};
    tbl[5] = '{0,  250, 1'b1,  250, 1'b0, 1'b0};
`ifdef PULSE_TIMEOUT_EN
    tbl[6] = '{2,  500, 1'b1,  300, 1'b0, 1'b1};
`else
    tbl[6] = '{2,  500, 1'b1,  500, 1'b0, 1'b0};
`endif

    // ---- reset state ----
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_micros_def", micros_def, 0);
    check("rst_tick_def", {31'd0, tick_def}, 0);
    check("rst_def_flags", {20'd0, valid_def, ovr_def, to_def}, 0);
    check("rst_def_fields", {31'd0, |{stamp_def, width_def}}, 0);
    check("rst_micros_main", micros_main, 0);
    check("rst_main_flags", {19'd0, tick_main, valid_main, ovr_main, to_main}, 0);
    check("rst_main_fields", {31'd0, |{stamp_main, width_main}}, 0);
    check("rst_w8", {micros_w8, stamp_w8, width_w8, 4'd0, tick_w8, valid_w8, ovr_w8, to_w8}, 0);
    reset = 1'b0;

    // ---- timebase: 500 clocks at 50 clk/us ----
    ticks  = 0;
    last_k = 0;
    for (int k = 1; k <= 500; k++) begin
      @(posedge clk); @(negedge clk);
      if (tick_def) begin
        ticks++;
        if (ticks == 1) check("first_tick_cycle", k, 49);
        else            check("tick_spacing", k - last_k, 50);
        last_k = k;
      end
    end
    check("tick_count_500", ticks, 10);
    check("micros_def_500", micros_def, 10);
    check("micros_main_500", micros_main, 250);
    $display("[TB] timebase: %0d ticks in 500 clocks, micros=%0d", ticks, micros_def);

    // ---- 8-bit wrap: rise at micros=250, 20 us wide ----
    guard = 0;
    while (model_micros[7:0] != 8'd249 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("wrap_wait_bound", {31'd0, guard < 1000}, 1);
    do_pulse(1'b1, 0, 40, 1'b0, st);
    check("w8_valid", {31'd0, valid_w8}, 1);
    check("w8_stamp", stamp_w8, 250);
    check("w8_width", width_w8, 20);
    check("w8_micros", micros_w8, {24'd0, model_micros[7:0]});
    $display("[TB] wrap: stamp=%0d width=%0d micros=%0d", stamp_w8, width_w8, micros_w8);

    // ---- table-driven captures on u_main ----
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].ack_before) begin
        ack_main[tbl[i].ch] = 1'b1;
        @(posedge clk); @(negedge clk);
        ack_main[tbl[i].ch] = 1'b0;
        check($sformatf("r%0d_ack_clears", i), {31'd0, valid_main[tbl[i].ch]}, 0);
      end
      do_pulse(1'b0, tbl[i].ch, tbl[i].high_us * 2, 1'b0, st);
      check($sformatf("r%0d_valid", i), {31'd0, valid_main[tbl[i].ch]}, 1);
      check($sformatf("r%0d_width", i), width_main[tbl[i].ch*16 +: 16], tbl[i].exp_width);
      check($sformatf("r%0d_stamp", i), stamp_main[tbl[i].ch*16 +: 16], st);
      check($sformatf("r%0d_overrun", i), {31'd0, ovr_main[tbl[i].ch]}, tbl[i].exp_overrun);
      check($sformatf("r%0d_timeout", i), {31'd0, to_main[tbl[i].ch]}, tbl[i].exp_timeout);
      $display("[TB] rec %0d ch%0d high=%0dus width=%0d stamp=%0d ovr=%0d to=%0d", i,
               tbl[i].ch, tbl[i].high_us, width_main[tbl[i].ch*16 +: 16],
               stamp_main[tbl[i].ch*16 +: 16], ovr_main[tbl[i].ch], to_main[tbl[i].ch]);
      repeat (3) @(negedge clk);
    end

    // ---- synchronous clear ----
    clear = 1'b1;
    @(posedge clk); @(negedge clk);
    clear = 1'b0;
    check("clr_micros", micros_main, 0);
    check("clr_flags", {20'd0, valid_main, ovr_main, to_main}, 0);
    check("clr_w8_valid", {31'd0, valid_w8}, 0);
    check("clr_keeps_width", width_main[15:0], 250);
    $display("[TB] clear: micros=%0d valid=%b ovr=%b", micros_main, valid_main, ovr_main);

    // ---- ack coinciding with a new capture ----
    do_pulse(1'b0, 1, 200, 1'b0, st);
    check("coin_first_width", width_main[31:16], 100);
    do_pulse(1'b0, 1, 100, 1'b1, st);
    check("coin_valid", {31'd0, valid_main[1]}, 1);
    check("coin_no_overrun", {31'd0, ovr_main[1]}, 0);
    check("coin_width", width_main[31:16], 50);
    check("coin_stamp", stamp_main[31:16], st);
    ack_main[1] = 1'b1;
    @(posedge clk); @(negedge clk);
    ack_main[1] = 1'b0;
    check("coin_ack_clears", {31'd0, valid_main[1]}, 0);
    $display("[TB] ack+capture: width=%0d ovr=%0d", width_main[31:16], ovr_main[1]);

    // ---- asynchronous reset mid-pulse, then enable frozen ----
    in_main[2] = 1'b1;
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_micros_main", micros_main, 0);
    check("arst_micros_def", micros_def, 0);
    check("arst_main_flags", {20'd0, valid_main, ovr_main, to_main}, 0);
    check("arst_main_fields", {31'd0, |{stamp_main, width_main}}, 0);
    in_main[2] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (21) @(negedge clk);
    check("pre_freeze_micros", micros_main, 10);
    enable = 1'b0;
    do_pulse(1'b0, 3, 40, 1'b0, st);
    check("frozen_width", width_main[63:48], 0);
    check("frozen_stamp", stamp_main[63:48], 10);
    ticks = 0;
    repeat (55) begin
      @(posedge clk); @(negedge clk);
      if (tick_main || tick_def) ticks++;
    end
    check("frozen_ticks", ticks, 0);
    check("frozen_micros", micros_main, 10);
    enable = 1'b1;
    do_pulse(1'b0, 2, 160, 1'b0, st);
    check("post_rst_valid", {31'd0, valid_main[2]}, 1);
    check("post_rst_width", width_main[47:32], 80);
    check("post_rst_stamp", stamp_main[47:32], st);
    $display("[TB] after reset: width=%0d stamp=%0d", width_main[47:32], stamp_main[47:32]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
